// File: rtl/tl_ul_pkg.sv
// Shared TileLink-UL definitions: channel opcodes, the D-channel response record
// and the lane-mask helper used for request legality checks.
package tl_ul_pkg;

    localparam int TL_SOURCE_W = 7;

    localparam logic [2:0] PUT_FULL    = 3'd0;
    localparam logic [2:0] PUT_PARTIAL = 3'd1;
    localparam logic [2:0] GET         = 3'd4;

    localparam logic [2:0] ACCESS_ACK      = 3'd0;
    localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;

    typedef struct packed {
        logic [2:0]             opcode;
        logic [2:0]             size;
        logic [TL_SOURCE_W-1:0] source;
        logic                   denied;
        logic                   corrupt;
        logic [31:0]            data;
    } tl_d_rsp_t;

    // Contiguous, size-aligned byte-lane mask; sizes above a word are rejected elsewhere.
    function automatic logic [3:0] full_mask(input logic [2:0] size, input logic [1:0] addr_lo);
        case (size)
            3'd0:    full_mask = 4'b0001 << addr_lo;
            3'd1:    full_mask = addr_lo[1] ? 4'b1100 : 4'b0011;
            default: full_mask = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/tl_rsp_fifo2.sv
// Two-entry response FIFO for the D channel; head reads back as zero while empty.
module tl_rsp_fifo2
    import tl_ul_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       push,
    input  tl_d_rsp_t  wdata,
    input  logic       pop,
    output tl_d_rsp_t  rdata,
    output logic [1:0] count
);

    tl_d_rsp_t mem [2];
    logic      rd_ptr;
    logic      wr_ptr;
    logic      do_push;
    logic      do_pop;

    assign do_push = push && (count != 2'd2);
    assign do_pop  = pop && (count != 2'd0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign rdata = (count == 2'd0) ? '0 : mem[rd_ptr];

endmodule

// File: rtl/tl_ul_sram_responder.sv
// TileLink-UL manager backed by a word-addressed SRAM: one decode/access stage
// feeding a two-entry in-order response queue.
module tl_ul_sram_responder
    import tl_ul_pkg::*;
#(
    parameter int SOURCE_W = TL_SOURCE_W,
    parameter int ADDR_W   = 12,
    parameter int DEPTH    = 256,
    parameter int BASE     = 0
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                a_valid,
    output logic                a_ready,
    input  logic [2:0]          a_opcode,
    input  logic [2:0]          a_param,
    input  logic [2:0]          a_size,
    input  logic [SOURCE_W-1:0] a_source,
    input  logic [ADDR_W-1:0]   a_address,
    input  logic [3:0]          a_mask,
    input  logic [31:0]         a_data,
    output logic                d_valid,
    input  logic                d_ready,
    output logic [2:0]          d_opcode,
    output logic [1:0]          d_param,
    output logic [2:0]          d_size,
    output logic [SOURCE_W-1:0] d_source,
    output logic                d_sink,
    output logic                d_denied,
    output logic                d_corrupt,
    output logic [31:0]         d_data
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int AW1   = ADDR_W + 1;

    logic [31:0]       sram [DEPTH];
    logic              fire;
    logic              is_get;
    logic              is_put;
    logic              aligned;
    logic              in_range;
    logic              mask_ok;
    logic              legal;
    logic [ADDR_W-1:0] offset;
    logic [IDX_W-1:0]  idx;
    logic              stage_valid;
    tl_d_rsp_t         stage_rsp;
    tl_d_rsp_t         rsp_next;
    tl_d_rsp_t         head;
    logic [1:0]        count;
    logic [2:0]        occupancy;

    // Occupancy counts the stage slot too, so a fired request always finds FIFO room.
    assign occupancy = {1'b0, count} + {2'b00, stage_valid};
    assign a_ready   = reset_n && (occupancy < 3'd2);
    assign fire      = a_valid && a_ready;

    assign is_get = (a_opcode == GET);
    assign is_put = (a_opcode == PUT_FULL) || (a_opcode == PUT_PARTIAL);

    always_comb begin
        case (a_size)
            3'd0:    aligned = 1'b1;
            3'd1:    aligned = ~a_address[0];
            3'd2:    aligned = (a_address[1:0] == 2'b00);
            default: aligned = 1'b0;
        endcase
    end

    assign in_range = ({1'b0, a_address} >= AW1'(BASE)) &&
                      ({1'b0, a_address} <  AW1'(BASE + 4 * DEPTH));
    assign mask_ok  = (a_opcode == PUT_PARTIAL) ||
                      (a_mask == full_mask(a_size, a_address[1:0]));
    assign legal    = (is_get || is_put) && (a_param == 3'd0) && (a_size <= 3'd2) &&
                      aligned && in_range && mask_ok;

    assign offset = a_address - ADDR_W'(BASE);
    assign idx    = offset[IDX_W+1:2];

    always_ff @(posedge clock) begin
        if (fire && legal && is_put) begin
            for (int i = 0; i < 4; i++) begin
                if (a_mask[i]) begin
                    sram[idx][8*i +: 8] <= a_data[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        rsp_next         = '0;
        rsp_next.opcode  = is_get ? ACCESS_ACK_DATA : ACCESS_ACK;
        rsp_next.size    = a_size;
        rsp_next.source  = a_source;
        rsp_next.denied  = !legal;
        rsp_next.corrupt = !legal && is_get;
        rsp_next.data    = (legal && is_get) ? sram[idx] : 32'd0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stage_valid <= 1'b0;
            stage_rsp   <= '0;
        end else begin
            stage_valid <= fire;
            if (fire) begin
                stage_rsp <= rsp_next;
            end
        end
    end

    tl_rsp_fifo2 u_rsp_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (stage_valid),
        .wdata   (stage_rsp),
        .pop     (d_valid && d_ready),
        .rdata   (head),
        .count   (count)
    );

    assign d_valid   = (count != 2'd0);
    assign d_opcode  = head.opcode;
    assign d_param   = 2'd0;
    assign d_size    = head.size;
    assign d_source  = head.source;
    assign d_sink    = 1'b0;
    assign d_denied  = head.denied;
    assign d_corrupt = head.corrupt;
    assign d_data    = head.data;

endmodule

// File: tb/tb_tl_ul_sram_responder.sv
// Self-checking bench: directed vector table, backpressure and reset sequences,
// then randomized traffic against a transaction-level reference model.
module tb_tl_ul_sram_responder;

    localparam int DEPTH = 256;
    localparam int BASE  = 0;

    logic        clock;
    logic        reset_n;
    logic        a_valid;
    logic        a_ready;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [2:0]  a_size;
    logic [6:0]  a_source;
    logic [11:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_valid;
    logic        d_ready;
    logic [2:0]  d_opcode;
    logic [1:0]  d_param;
    logic [2:0]  d_size;
    logic [6:0]  d_source;
    logic        d_sink;
    logic        d_denied;
    logic        d_corrupt;
    logic [31:0] d_data;

    tl_ul_sram_responder dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_opcode  (a_opcode),
        .a_param   (a_param),
        .a_size    (a_size),
        .a_source  (a_source),
        .a_address (a_address),
        .a_mask    (a_mask),
        .a_data    (a_data),
        .d_valid   (d_valid),
        .d_ready   (d_ready),
        .d_opcode  (d_opcode),
        .d_param   (d_param),
        .d_size    (d_size),
        .d_source  (d_source),
        .d_sink    (d_sink),
        .d_denied  (d_denied),
        .d_corrupt (d_corrupt),
        .d_data    (d_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]  opcode;
        logic [2:0]  size;
        logic [6:0]  source;
        logic        denied;
        logic        corrupt;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic [2:0]  op;
        logic [2:0]  param;
        logic [2:0]  size;
        logic [6:0]  src;
        logic [11:0] addr;
        logic [3:0]  mask;
        logic [31:0] data;
        logic [2:0]  eop;
        logic        eden;
        logic [31:0] edata;
    } vec_t;

    int          errors = 0;
    int          checks = 0;
    bit          last_fire = 0;
    logic [31:0] ref_mem [DEPTH];
    exp_t        exp_q [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: legality and memory effect computed from the protocol rules.
    task automatic model(input logic [2:0] op, input logic [2:0] param, input logic [2:0] size,
                         input logic [6:0] src, input logic [11:0] addr, input logic [3:0] mask,
                         input logic [31:0] data, output exp_t r);
        bit          legal;
        int unsigned nbytes;
        int unsigned a;
        int unsigned word;
        logic [3:0]  want;
        a      = addr;
        nbytes = 1 << size;
        legal  = (op == 0 || op == 1 || op == 4) && (param == 0) && (size <= 2);
        want   = 4'((((1 << nbytes) - 1) << (a % 4)));
        if (a % nbytes != 0) legal = 0;
        if (a < BASE || a >= BASE + 4 * DEPTH) legal = 0;
        if ((op == 0 || op == 4) && mask != want) legal = 0;
        word      = (a - BASE) / 4;
        r.opcode  = (op == 4) ? 3'd1 : 3'd0;
        r.size    = size;
        r.source  = src;
        r.denied  = !legal;
        r.corrupt = !legal && (op == 4);
        r.data    = (legal && op == 4) ? ref_mem[word] : 32'd0;
        if (legal && (op == 0 || op == 1)) begin
            for (int b = 0; b < 4; b++) begin
                if (mask[b]) ref_mem[word][8*b +: 8] = data[8*b +: 8];
            end
        end
    endtask

    // One clock: check any popped response against the model queue, then account for a fire.
    task automatic tick();
        bit          f;
        bit          p;
        exp_t        e;
        logic [2:0]  op, pa, sz;
        logic [6:0]  src;
        logic [11:0] ad;
        logic [3:0]  mk;
        logic [31:0] dt;
        f = a_valid && a_ready;
        p = d_valid && d_ready;
        op = a_opcode; pa = a_param; sz = a_size; src = a_source;
        ad = a_address; mk = a_mask; dt = a_data;
        if (p) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", {63'd0, d_valid}, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_vs_model",
                    {12'd0, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_corrupt, d_data},
                    {12'd0, e.opcode, 2'd0, e.size, e.source, 1'b0, e.denied, e.corrupt, e.data});
            end
        end
        @(posedge clock);
        #1;
        last_fire = f;
        if (f) begin
            model(op, pa, sz, src, ad, mk, dt, e);
            exp_q.push_back(e);
        end
    endtask

    task automatic set_req(input logic [2:0] op, input logic [2:0] param, input logic [2:0] size,
                           input logic [6:0] src, input logic [11:0] addr, input logic [3:0] mask,
                           input logic [31:0] data);
        a_opcode = op; a_param = param; a_size = size; a_source = src;
        a_address = addr; a_mask = mask; a_data = data;
    endtask

    task automatic issue(input logic [2:0] op, input logic [2:0] size, input logic [11:0] addr,
                         input logic [3:0] mask, input logic [31:0] data);
        bit done;
        done = 0;
        set_req(op, 3'd0, size, 7'd1, addr, mask, data);
        a_valid = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            tick();
            done = last_fire;
        end
        a_valid = 1'b0;
        if (!done) chk("issue_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        a_valid = 1'b0;
        d_ready = 1'b1;
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    vec_t vecs [$];

    initial begin
        vec_t        v;
        int          n;
        int          acc;
        logic [63:0] snap;

        vecs = '{
            '{3'd0, 3'd0, 3'd2, 7'd5, 12'h010, 4'hF, 32'hDEADBEEF, 3'd0, 1'b0, 32'h0},
            '{3'd4, 3'd0, 3'd2, 7'd5, 12'h010, 4'hF, 32'h0,        3'd1, 1'b0, 32'hDEADBEEF},
            '{3'd1, 3'd0, 3'd2, 7'd6, 12'h010, 4'h2, 32'h0000AA00, 3'd0, 1'b0, 32'h0},
            '{3'd4, 3'd0, 3'd2, 7'd7, 12'h010, 4'hF, 32'h0,        3'd1, 1'b0, 32'hDEADAAEF},
            '{3'd4, 3'd0, 3'd2, 7'd8, 12'h400, 4'hF, 32'h0,        3'd1, 1'b1, 32'h0},
            '{3'd3, 3'd0, 3'd2, 7'd9, 12'h010, 4'hF, 32'h55555555, 3'd0, 1'b1, 32'h0},
            '{3'd4, 3'd0, 3'd2, 7'd9, 12'h010, 4'hF, 32'h0,        3'd1, 1'b0, 32'hDEADAAEF},
            '{3'd4, 3'd0, 3'd1, 7'd2, 12'h011, 4'h6, 32'h0,        3'd1, 1'b1, 32'h0},
            '{3'd4, 3'd0, 3'd3, 7'd2, 12'h010, 4'hF, 32'h0,        3'd1, 1'b1, 32'h0},
            '{3'd4, 3'd1, 3'd2, 7'd3, 12'h010, 4'hF, 32'h0,        3'd1, 1'b1, 32'h0},
            '{3'd0, 3'd0, 3'd2, 7'd4, 12'h020, 4'h7, 32'h99999999, 3'd0, 1'b1, 32'h0},
            '{3'd0, 3'd0, 3'd2, 7'd4, 12'h020, 4'hF, 32'h11111111, 3'd0, 1'b0, 32'h0},
            '{3'd0, 3'd0, 3'd1, 7'd4, 12'h022, 4'hC, 32'h12340000, 3'd0, 1'b0, 32'h0},
            '{3'd4, 3'd0, 3'd1, 7'd4, 12'h022, 4'hC, 32'h0,        3'd1, 1'b0, 32'h12341111},
            '{3'd4, 3'd0, 3'd0, 7'd4, 12'h023, 4'h8, 32'h0,        3'd1, 1'b0, 32'h12341111},
            '{3'd4, 3'd0, 3'd0, 7'd4, 12'h023, 4'h1, 32'h0,        3'd1, 1'b1, 32'h0},
            '{3'd4, 3'd0, 3'd2, 7'd4, 12'h010, 4'hF, 32'h0,        3'd1, 1'b0, 32'hDEADAAEF}
        };

        reset_n = 1'b0;
        a_valid = 1'b0;
        d_ready = 1'b0;
        set_req(3'd0, 3'd0, 3'd0, 7'd0, 12'd0, 4'd0, 32'd0);
        #1;
        chk("reset_a_ready", {63'd0, a_ready}, 64'd0);
        chk("reset_d_fields", {d_valid, d_opcode, d_size, d_source, d_denied, d_corrupt, d_data},
            64'd0);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        #1;
        chk("post_reset_ready", {63'd0, a_ready}, 64'd1);
        d_ready = 1'b1;

        foreach (vecs[k]) begin
            v = vecs[k];
            set_req(v.op, v.param, v.size, v.src, v.addr, v.mask, v.data);
            a_valid = 1'b1;
            tick();
            a_valid = 1'b0;
            chk("vec_fire", {63'd0, last_fire}, 64'd1);
            chk("vec_stage_no_dvalid", {63'd0, d_valid}, 64'd0);
            tick();
            chk("vec_dvalid_latency", {63'd0, d_valid}, 64'd1);
            chk("vec_rsp", {18'd0, d_opcode, d_source, d_denied, d_corrupt, d_data},
                {18'd0, v.eop, v.src, v.eden, v.eden && (v.op == 3'd4), v.edata});
            tick();
        end
        drain();

        // Backpressure: only two requests fit while D is stalled.
        d_ready = 1'b0;
        n = 0;
        acc = 0;
        set_req(3'd4, 3'd0, 3'd2, 7'd10, 12'h010, 4'hF, 32'd0);
        a_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (last_fire) begin
                acc++;
                n++;
                a_source = 7'(10 + n);
            end
        end
        chk("bp_accepted", 64'(acc), 64'd2);
        chk("bp_a_ready_low", {63'd0, a_ready}, 64'd0);
        snap = {d_valid, d_opcode, d_size, d_source, d_denied, d_corrupt, d_data};
        for (int c = 0; c < 3; c++) tick();
        chk("bp_d_stable", {d_valid, d_opcode, d_size, d_source, d_denied, d_corrupt, d_data}, snap);
        chk("bp_head_source", 64'(d_source), 64'd10);
        d_ready = 1'b1;
        for (int c = 0; c < 40 && n < 4; c++) begin
            tick();
            if (last_fire) begin
                n++;
                a_source = 7'(10 + n);
                if (n == 4) a_valid = 1'b0;
            end
        end
        a_valid = 1'b0;
        chk("bp_remaining_accepted", 64'(n), 64'd4);
        drain();

        // Reset with two responses queued.
        d_ready = 1'b0;
        n = 0;
        set_req(3'd4, 3'd0, 3'd2, 7'd20, 12'h010, 4'hF, 32'd0);
        a_valid = 1'b1;
        for (int c = 0; c < 10 && n < 2; c++) begin
            tick();
            if (last_fire) begin
                n++;
                a_source = 7'(20 + n);
            end
        end
        a_valid = 1'b0;
        tick();
        tick();
        chk("rst_pre_dvalid", {63'd0, d_valid}, 64'd1);
        #3;
        reset_n = 1'b0;
        #1;
        chk("rst_dvalid_immediate", {63'd0, d_valid}, 64'd0);
        chk("rst_fields_zero", {d_opcode, d_size, d_source, d_denied, d_corrupt, d_data}, 64'd0);
        chk("rst_a_ready_low", {63'd0, a_ready}, 64'd0);
        exp_q.delete();
        @(posedge clock);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        #1;
        chk("rst_ready_first_cycle", {63'd0, a_ready}, 64'd1);
        d_ready = 1'b1;
        for (int c = 0; c < 6; c++) tick();
        chk("rst_no_stale", {63'd0, d_valid}, 64'd0);

        // Random traffic over a prefilled window of 16 words plus out-of-range probes.
        for (int w = 0; w < 16; w++) issue(3'd0, 3'd2, 12'(4 * w), 4'hF, $urandom);
        drain();
        a_valid = 1'b0;
        last_fire = 0;
        for (int c = 0; c < 1500; c++) begin
            if (!a_valid || last_fire) begin
                if ($urandom % 4 == 0) begin
                    a_valid = 1'b0;
                end else begin
                    int unsigned r;
                    int unsigned sz;
                    int unsigned ad;
                    logic [2:0]  op;
                    logic [3:0]  mk;
                    r  = $urandom % 16;
                    op = (r < 5) ? 3'd4 : (r < 9) ? 3'd0 : (r < 13) ? 3'd1 : 3'($urandom % 8);
                    sz = ($urandom % 8 == 0) ? 3 : $urandom % 3;
                    ad = ($urandom % 10 == 0) ? $urandom_range(1024, 4095) : $urandom % 64;
                    ad = ad & ~((1 << (sz > 2 ? 0 : sz)) - 1);
                    if ($urandom % 8 == 0) ad = ad | ($urandom % 4);
                    mk = 4'(((1 << (1 << sz)) - 1) << (ad % 4));
                    if (op == 3'd1 || $urandom % 5 == 0) mk = 4'($urandom);
                    set_req(op, ($urandom % 12 == 0) ? 3'($urandom_range(1, 7)) : 3'd0,
                            3'(sz), 7'($urandom), 12'(ad), mk, $urandom);
                    a_valid = 1'b1;
                end
            end
            d_ready = ($urandom % 4) != 0;
            tick();
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
